// File: rtl/resp_arbiter_if.sv
// Response arbiter bus: capture inputs, FIFO write side and status.
// master drives requests/backpressure, slave is the arbiter.
interface resp_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    Rd_data;
    logic                     Rd_data_valid;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_valid;
    logic                     Full;
    logic                     Err_Clr;
    logic [DATA_WIDTH-1:0]    FIFO_IN;
    logic                     Wr_Req;
    logic                     Busy;
    logic                     Ovf_Err;

    modport master (
        output Rd_data, Rd_data_valid, ALU_OUT, ALU_OUT_valid,
        output Full, Err_Clr,
        input  FIFO_IN, Wr_Req, Busy, Ovf_Err
    );

    modport slave (
        input  Rd_data, Rd_data_valid, ALU_OUT, ALU_OUT_valid,
        input  Full, Err_Clr,
        output FIFO_IN, Wr_Req, Busy, Ovf_Err
    );
endinterface

// File: rtl/resp_arbiter.sv
// Round-robin response sequencer: holds one RD byte and one ALU result,
// serialises grants into single-cycle TX FIFO writes with a gap cycle.
module resp_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
) (
    input logic           CLK,
    input logic           RST,
    resp_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        SEND_RD,
        SEND_ALU_LO,
        SEND_ALU_HI,
        GAP
    } state_e;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    rd_q, rd_d;
    logic                     rd_pend_q, rd_pend_d;
    logic [ALU_OUT_WIDTH-1:0] alu_q, alu_d;
    logic                     alu_pend_q, alu_pend_d;
    logic                     last_alu_q, last_alu_d;
    logic                     hi_next_q, hi_next_d;
    logic [DATA_WIDTH-1:0]    fifo_q, fifo_d;
    logic                     wr_q, wr_d;
    logic                     busy_q, busy_d;
    logic                     ovf_q, ovf_d;
    logic                     rd_clr, alu_clr;
    logic                     rd_ovf, alu_ovf;

    always_comb begin
        state_d    = state_q;
        last_alu_d = last_alu_q;
        hi_next_d  = hi_next_q;
        fifo_d     = fifo_q;
        wr_d       = 1'b0;
        rd_clr     = 1'b0;
        alu_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Only ties move the round-robin pointer.
                if (rd_pend_q && alu_pend_q) begin
                    if (last_alu_q) begin
                        state_d    = SEND_RD;
                        last_alu_d = 1'b0;
                    end else begin
                        state_d    = SEND_ALU_LO;
                        last_alu_d = 1'b1;
                    end
                end else if (rd_pend_q) begin
                    state_d = SEND_RD;
                end else if (alu_pend_q) begin
                    state_d = SEND_ALU_LO;
                end
            end
            SEND_RD: begin
                if (!bus.Full) begin
                    wr_d      = 1'b1;
                    fifo_d    = rd_q;
                    rd_clr    = 1'b1;
                    hi_next_d = 1'b0;
                    state_d   = GAP;
                end
            end
            SEND_ALU_LO: begin
                if (!bus.Full) begin
                    wr_d      = 1'b1;
                    fifo_d    = alu_q[DATA_WIDTH-1:0];
                    hi_next_d = 1'b1;
                    state_d   = GAP;
                end
            end
            SEND_ALU_HI: begin
                if (!bus.Full) begin
                    wr_d      = 1'b1;
                    fifo_d    = alu_q[ALU_OUT_WIDTH-1:DATA_WIDTH];
                    alu_clr   = 1'b1;
                    hi_next_d = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                state_d   = hi_next_q ? SEND_ALU_HI : IDLE;
                hi_next_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d       = rd_q;
        rd_pend_d  = rd_pend_q && !rd_clr;
        rd_ovf     = 1'b0;
        alu_d      = alu_q;
        alu_pend_d = alu_pend_q && !alu_clr;
        alu_ovf    = 1'b0;
        // A holder drained on this edge can take new data.
        if (bus.Rd_data_valid) begin
            if (!rd_pend_d) begin
                rd_d      = bus.Rd_data;
                rd_pend_d = 1'b1;
            end else begin
                rd_ovf = 1'b1;
            end
        end
        if (bus.ALU_OUT_valid) begin
            if (!alu_pend_d) begin
                alu_d      = bus.ALU_OUT;
                alu_pend_d = 1'b1;
            end else begin
                alu_ovf = 1'b1;
            end
        end
        if (rd_ovf || alu_ovf) begin
            ovf_d = 1'b1;
        end else if (bus.Err_Clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        busy_d = (state_d != IDLE) || rd_pend_d || alu_pend_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            rd_pend_q  <= 1'b0;
            alu_q      <= '0;
            alu_pend_q <= 1'b0;
            last_alu_q <= 1'b1;
            hi_next_q  <= 1'b0;
            fifo_q     <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            rd_pend_q  <= rd_pend_d;
            alu_q      <= alu_d;
            alu_pend_q <= alu_pend_d;
            last_alu_q <= last_alu_d;
            hi_next_q  <= hi_next_d;
            fifo_q     <= fifo_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.FIFO_IN = fifo_q;
    assign bus.Wr_Req  = wr_q;
    assign bus.Busy    = busy_q;
    assign bus.Ovf_Err = ovf_q;
endmodule

// File: tb/tb_resp_arbiter.sv
// Directed bench for resp_arbiter: latency, round-robin order,
// backpressure, overflow and mid-frame reset.
module tb_resp_arbiter;
    logic CLK;
    logic RST;
    int   n_chk;
    int   n_err;
    int   viol;
    logic prev_wr;
    logic full_s;
    logic [7:0] got[$];

    resp_arbiter_if #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) bus ();

    resp_arbiter #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) full_s <= bus.Full;

    // Byte log plus strobe-rule watchdog.
    always @(negedge CLK) begin
        if (bus.Wr_Req === 1'b1) begin
            got.push_back(bus.FIFO_IN);
            if (prev_wr) viol++;
            if (full_s) viol++;
        end
        prev_wr = (bus.Wr_Req === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_q(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(tag, got[i], exp[i]);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        viol = 0;
        prev_wr = 1'b0;
        RST = 1'b1;
        bus.Rd_data = 8'h00;
        bus.Rd_data_valid = 1'b0;
        bus.ALU_OUT = 16'h0000;
        bus.ALU_OUT_valid = 1'b0;
        bus.Full = 1'b0;
        bus.Err_Clr = 1'b0;
        tick(2);
        chk("rst_fifo", bus.FIFO_IN, 8'h00);
        chk("rst_wr", bus.Wr_Req, 1'b0);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_ovf", bus.Ovf_Err, 1'b0);
        RST = 1'b0;
        tick(1);

        // RD only: cycle 0 pulse
        bus.Rd_data = 8'hA5;
        bus.Rd_data_valid = 1'b1;
        tick(1);
        bus.Rd_data_valid = 1'b0;
        chk("rd_busy_c1", bus.Busy, 1'b1);
        chk("rd_wr_c1", bus.Wr_Req, 1'b0);
        tick(1);
        chk("rd_wr_c2", bus.Wr_Req, 1'b0);
        tick(1);
        chk("rd_wr_c3", bus.Wr_Req, 1'b1);
        chk("rd_fifo_c3", bus.FIFO_IN, 8'hA5);
        tick(1);
        chk("rd_wr_c4", bus.Wr_Req, 1'b0);
        chk("rd_hold_c4", bus.FIFO_IN, 8'hA5);
        tick(1);
        chk("rd_busy_c5", bus.Busy, 1'b0);
        tick(3);
        got.delete();

        // ALU only
        bus.ALU_OUT = 16'h1234;
        bus.ALU_OUT_valid = 1'b1;
        tick(1);
        bus.ALU_OUT_valid = 1'b0;
        tick(2);
        chk("alu_wr_c3", bus.Wr_Req, 1'b1);
        chk("alu_lo_c3", bus.FIFO_IN, 8'h34);
        tick(1);
        chk("alu_wr_c4", bus.Wr_Req, 1'b0);
        tick(1);
        chk("alu_wr_c5", bus.Wr_Req, 1'b1);
        chk("alu_hi_c5", bus.FIFO_IN, 8'h12);
        tick(4);
        chk("alu_busy_end", bus.Busy, 1'b0);
        got.delete();

        // Simultaneous after reset, then round-robin flip
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(1);
        bus.Rd_data = 8'h55;
        bus.ALU_OUT = 16'hBEEF;
        bus.Rd_data_valid = 1'b1;
        bus.ALU_OUT_valid = 1'b1;
        tick(1);
        bus.Rd_data_valid = 1'b0;
        bus.ALU_OUT_valid = 1'b0;
        tick(14);
        chk_q("tie1", '{8'h55, 8'hEF, 8'hBE});
        got.delete();
        bus.Rd_data = 8'h66;
        bus.ALU_OUT = 16'hCAFE;
        bus.Rd_data_valid = 1'b1;
        bus.ALU_OUT_valid = 1'b1;
        tick(1);
        bus.Rd_data_valid = 1'b0;
        bus.ALU_OUT_valid = 1'b0;
        tick(14);
        chk_q("tie2", '{8'hFE, 8'hCA, 8'h66});
        got.delete();

        // Backpressure between LO and HI
        bus.ALU_OUT = 16'h00FF;
        bus.ALU_OUT_valid = 1'b1;
        tick(1);
        bus.ALU_OUT_valid = 1'b0;
        tick(2);
        chk("bp_lo", bus.FIFO_IN, 8'hFF);
        bus.Full = 1'b1;
        tick(10);
        chk("bp_stall_len", got.size(), 1);
        chk("bp_stall_wr", bus.Wr_Req, 1'b0);
        chk("bp_stall_busy", bus.Busy, 1'b1);
        bus.Full = 1'b0;
        tick(6);
        chk_q("bp", '{8'hFF, 8'h00});
        got.delete();

        // Overflow while FIFO is full
        bus.Full = 1'b1;
        bus.Rd_data = 8'h11;
        bus.Rd_data_valid = 1'b1;
        tick(1);
        chk("ovf_none", bus.Ovf_Err, 1'b0);
        bus.Rd_data = 8'h22;
        tick(1);
        bus.Rd_data_valid = 1'b0;
        chk("ovf_set", bus.Ovf_Err, 1'b1);
        tick(3);
        bus.Full = 1'b0;
        tick(6);
        chk_q("ovf", '{8'h11});
        got.delete();
        bus.Err_Clr = 1'b1;
        tick(1);
        bus.Err_Clr = 1'b0;
        chk("ovf_clr", bus.Ovf_Err, 1'b0);
        bus.Full = 1'b1;
        bus.Rd_data = 8'h33;
        bus.Rd_data_valid = 1'b1;
        tick(1);
        bus.Rd_data = 8'h44;
        bus.Err_Clr = 1'b1;
        tick(1);
        bus.Rd_data_valid = 1'b0;
        bus.Err_Clr = 1'b0;
        chk("ovf_set_wins", bus.Ovf_Err, 1'b1);
        bus.Full = 1'b0;
        tick(6);
        chk_q("ovf2", '{8'h33});
        got.delete();
        bus.Err_Clr = 1'b1;
        tick(1);
        bus.Err_Clr = 1'b0;

        // Reset between LO and HI
        bus.ALU_OUT = 16'hABCD;
        bus.ALU_OUT_valid = 1'b1;
        tick(1);
        bus.ALU_OUT_valid = 1'b0;
        tick(2);
        chk("mr_lo", bus.FIFO_IN, 8'hCD);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("mr_fifo", bus.FIFO_IN, 8'h00);
        chk("mr_wr", bus.Wr_Req, 1'b0);
        chk("mr_busy", bus.Busy, 1'b0);
        chk("mr_ovf", bus.Ovf_Err, 1'b0);
        tick(6);
        chk_q("mr_nohi", '{8'hCD});
        bus.Rd_data = 8'h77;
        bus.Rd_data_valid = 1'b1;
        tick(1);
        bus.Rd_data_valid = 1'b0;
        tick(6);
        chk_q("mr_next", '{8'hCD, 8'h77});

        chk("strobe_rules", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/resp_arbiter.md
Name: resp_arbiter

Overview:
- Response arbiter/sequencer on the REF_CLK side. It sits between the register file read port, the ALU result port and the TX async FIFO write port.
- It captures register-read bytes and ALU results into one-deep holding registers and arbitrates between them round-robin.
- It serialises each grant into byte writes (ALU results as low byte then high byte), honouring FIFO Full backpressure.
- It replaces ad-hoc response muxing in the system controller with one dedicated scheduler.

Parameters:
- DATA_WIDTH, 8, byte width of the FIFO and of register read data.
- ALU_OUT_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH.

Ports:
- CLK  input  1  clock (REF_CLK domain); all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Rd_data  input  DATA_WIDTH  register file read data.
- Rd_data_valid  input  1  one-cycle pulse qualifying Rd_data.
- ALU_OUT  input  ALU_OUT_WIDTH  ALU result.
- ALU_OUT_valid  input  1  one-cycle pulse qualifying ALU_OUT.
- Full  input  1  TX FIFO full flag.
- Err_Clr  input  1  clears Ovf_Err.
- FIFO_IN  output  DATA_WIDTH  byte to FIFO; registered.
- Wr_Req  output  1  FIFO write strobe, one cycle per byte; registered.
- Busy  output  1  high while any holding register is occupied or the FSM is not IDLE.
- Ovf_Err  output  1  sticky overflow flag: a response was dropped.

Behaviour:
- Reset: CLK rising edge with RST=1 clears everything:
  - FIFO_IN=0, Wr_Req=0, Busy=0, Ovf_Err=0.
  - Both holding registers empty; FSM=IDLE; last_grant=ALU.
  - RST mid-frame abandons the frame; a half-sent ALU result is not completed.
- Capture:
  - Rd_data_valid=1 with RD holder empty: latch Rd_data, set rd_pend. ALU_OUT_valid does the same into the ALU holder (alu_pend).
  - Valid while the holder is occupied: new data dropped, holder unchanged, Ovf_Err set.
  - A holder freed on the same edge that a new valid arrives accepts the new data, with no overflow.
  - Both valids in the same cycle: both captured independently.
- Ovf_Err is cleared by Err_Clr=1. If a set and a clear occur in the same cycle, set wins.
- FSM states: IDLE, SEND_RD, SEND_ALU_LO, SEND_ALU_HI, GAP.
  - IDLE:
    - only rd_pend -> SEND_RD.
    - only alu_pend -> SEND_ALU_LO.
    - both pending: grant the source opposite to last_grant, then update last_grant. First tie after reset goes to RD.
  - SEND_RD: stall while Full=1. With Full=0: register Wr_Req=1 and FIFO_IN=held byte, clear rd_pend, go to GAP.
  - SEND_ALU_LO: stall while Full=1. With Full=0: write ALU[7:0], go to GAP, and return to SEND_ALU_HI afterwards.
  - SEND_ALU_HI: stall while Full=1. With Full=0: write ALU[15:8], clear alu_pend, go to GAP.
  - GAP: exactly one cycle with Wr_Req=0, so FIFO Full can update. Then go to SEND_ALU_HI if the LO byte was just sent, else IDLE.
  - Arbitration happens only in IDLE. An ALU frame (LO+HI) is never interleaved with an RD byte.
- Write strobe rules:
  - Wr_Req is never high on two consecutive cycles.
  - Wr_Req is never asserted on an edge where Full was sampled 1.
  - FIFO_IN holds its last value when Wr_Req=0.
- Latency, uncontended, with Full=0 and the valid pulse in cycle 0:
  - pend visible in cycle 1; SEND state in cycle 2; Wr_Req high in cycle 3.
  - For an ALU result, the HI byte's Wr_Req is high in cycle 5.
- Busy is registered, with the same timing as pend/state; it is low only when IDLE and both holders are empty.

Test Plan:
- RD only: Rd_data=0xA5 pulse in cycle 0, Full=0 -> Wr_Req=1 with FIFO_IN=0xA5 in cycle 3 only; Busy low again by cycle 5.
- ALU only: ALU_OUT=0x1234 pulse, Full=0 -> FIFO_IN=0x34 in cycle 3 and 0x12 in cycle 5; Wr_Req low in cycle 4.
- Simultaneous after reset: Rd_data=0x55 and ALU_OUT=0xBEEF in the same cycle -> bytes 0x55, 0xEF, 0xBE in order. Repeat with 0x66/0xCAFE -> order 0xFE, 0xCA, 0x66 (round-robin).
- Backpressure: ALU_OUT=0x00FF, Full held 1 for 10 cycles after LO is sent -> HI byte 0x00 issued only after Full drops. No Wr_Req while Full=1; no byte lost or duplicated.
- Overflow: hold Full=1, pulse Rd_data=0x11 then Rd_data=0x22 -> Ovf_Err=1; after release only 0x11 is written. Err_Clr pulse -> Ovf_Err=0; set and clear in the same cycle -> Ovf_Err stays 1.
- Reset mid-frame: assert RST for 1 cycle between the LO and HI bytes of 0xABCD -> all outputs 0, no 0xAB write. The next RD 0x77 is sent normally.
